// File: rtl/strobe_pkg.sv
// Shared types and default widths for the strobe source and its neighbours.
package strobe_pkg;
  localparam int PER_W_DEF = 16;
  localparam int NUM_W_DEF = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/strobe_period_cnt.sv
// Loadable down-counter with enable; holds at zero rather than wrapping.
module strobe_period_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ena,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_cnt <= '0;
    else if (i_ena && i_load)               r_cnt <= i_val;
    else if (i_ena && i_dec && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/strobe_gen.sv
// Programmable strobe source: finite bursts or continuous strobes at a
// latched period, started and stopped at run time.
module strobe_gen
  import strobe_pkg::*;
#(
  parameter int PER_W = PER_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic [PER_W-1:0] period,
  input  logic [NUM_W-1:0] count,
  output logic             str,
  output logic             busy,
  output logic             done
);
  state_t           r_state;
  logic [PER_W-1:0] r_per_q;
  logic             r_inf_q;
  logic             r_str;
  logic             r_done;

  logic [PER_W-1:0] w_per_eff;
  logic [PER_W-1:0] w_per_val;
  logic [PER_W-1:0] w_per_cnt;
  logic             w_per_zero;
  logic [NUM_W-1:0] w_rem;
  logic [NUM_W-1:0] w_rem_val;
  logic             w_rem_zero;
  logic             w_in_run;
  logic             w_accept;
  logic             w_halt;
  logic             w_due;
  logic             w_last;
  logic             w_one;

  assign w_per_eff = (period == '0) ? PER_W'(1) : period;
  assign w_in_run  = (r_state == RUN);
  // stop beats both a start in IDLE and a strobe due in RUN
  assign w_accept  = ena && start && !stop && !w_in_run;
  assign w_halt    = ena && w_in_run && stop;
  assign w_due     = ena && w_in_run && !stop && w_per_zero;
  assign w_last    = w_due && !r_inf_q && (w_rem == NUM_W'(1));
  assign w_one     = (count == NUM_W'(1));
  assign w_per_val = w_accept ? (w_per_eff - PER_W'(1)) : (r_per_q - PER_W'(1));
  assign w_rem_val = (count == '0) ? '0 : (count - NUM_W'(1));

  strobe_period_cnt #(.W(PER_W)) u_per (
    .clk    (clk),
    .rst    (rst),
    .i_ena  (ena),
    .i_load (w_accept || w_due),
    .i_val  (w_per_val),
    .i_dec  (w_in_run && !stop),
    .o_cnt  (w_per_cnt),
    .o_zero (w_per_zero)
  );

  strobe_period_cnt #(.W(NUM_W)) u_rem (
    .clk    (clk),
    .rst    (rst),
    .i_ena  (ena),
    .i_load (w_accept),
    .i_val  (w_rem_val),
    .i_dec  (w_due && !r_inf_q),
    .o_cnt  (w_rem),
    .o_zero (w_rem_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_per_q <= '0;
      r_inf_q <= 1'b0;
      r_str   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // str/done are single-cycle: cleared on every edge, even when frozen
      r_str  <= w_accept || w_due;
      r_done <= (w_accept && w_one) || w_last;
      if (w_accept) begin
        r_per_q <= w_per_eff;
        r_inf_q <= (count == '0);
        if (!w_one) r_state <= RUN;
      end else if (w_halt || w_last) begin
        r_state <= IDLE;
      end
    end
  end

  assign str  = r_str;
  assign done = r_done;
  assign busy = w_in_run || r_str;

  logic w_unused;
  assign w_unused = ^{w_per_cnt, w_rem_zero};
endmodule

// File: tb/tb_strobe_gen.sv
// Directed bench for strobe_gen: per-cycle str/done/busy against hand masks.
module tb_strobe_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        ena, start, stop;
  logic [15:0] period;
  logic [7:0]  count;
  logic        str, busy, done;

  int n_chk = 0;
  int n_err = 0;

  strobe_gen #(.PER_W(16), .NUM_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop),
    .period(period), .count(count), .str(str), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle c starts 1 time unit after a rising edge; inputs set in cycle c
  // are sampled at the edge ending it, outputs seen in c reflect edge c-1.
  task automatic run(input string name, input logic [15:0] per, input logic [7:0] cnt,
                     input logic [31:0] st_m, input logic [31:0] sp_m, input logic [31:0] elo_m,
                     input logic [31:0] e_str, input logic [31:0] e_done, input logic [31:0] e_busy);
    period = per;
    count  = cnt;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      chk($sformatf("%s c%0d str", name, c),  {31'd0, str},  {31'd0, e_str[c]});
      chk($sformatf("%s c%0d done", name, c), {31'd0, done}, {31'd0, e_done[c]});
      chk($sformatf("%s c%0d busy", name, c), {31'd0, busy}, {31'd0, e_busy[c]});
      start = st_m[c];
      stop  = sp_m[c];
      ena   = ~elo_m[c];
    end
    start = 1'b0; stop = 1'b0; ena = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; start = 1'b0; stop = 1'b0; period = '0; count = '0;
    #12;
    chk("reset str", {31'd0, str}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    run("p4c3", 16'd4, 8'd3, 32'h1, 32'h0, 32'h0,
        (32'h1 << 1) | (32'h1 << 5) | (32'h1 << 9), 32'h1 << 9, 32'h3FE);
    run("p0c2", 16'd0, 8'd2, 32'h1, 32'h0, 32'h0, 32'h6, 32'h4, 32'h6);
    run("p0c1", 16'd0, 8'd1, 32'h1, 32'h0, 32'h0, 32'h2, 32'h2, 32'h2);
    run("p3cont", 16'd3, 8'd0, 32'h1, 32'h1 << 8, 32'h0,
        (32'h1 << 1) | (32'h1 << 4) | (32'h1 << 7), 32'h0, 32'h1FE);
    run("enagap", 16'd4, 8'd2, 32'h1 | (32'h1 << 6), 32'h0, 32'h1C,
        (32'h1 << 1) | (32'h1 << 8), 32'h1 << 8, 32'h1FE);
    run("startstop", 16'd4, 8'd3, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);
    run("stopdue", 16'd2, 8'd0, 32'h1, 32'h4, 32'h0, 32'h2, 32'h0, 32'h6);

    // Asynchronous reset while a strobe is high mid-burst
    period = 16'd4; count = 8'd0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("pre-rst str c1", {31'd0, str}, 32'd1);
    repeat (4) @(posedge clk);
    #1 chk("pre-rst str c5", {31'd0, str}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async rst str", {31'd0, str}, 32'd0);
    chk("async rst done", {31'd0, done}, 32'd0);
    chk("async rst busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    run("fresh", 16'd4, 8'd3, 32'h1, 32'h0, 32'h0,
        (32'h1 << 1) | (32'h1 << 5) | (32'h1 << 9), 32'h1 << 9, 32'h3FE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/strobe_gen.md
Name: strobe_gen

Overview:
Programmable strobe source that sits directly upstream of the pulse stretcher. It emits single-cycle strobes on str, spaced by a run-time period, either as a finite burst or continuously. Software or a control FSM starts and stops it. The downstream stretcher widens each strobe for LEDs, triggers or external pins.

Parameters:
PER_W, 16, width of period input and period counter
NUM_W, 8, width of strobe-count input and remaining-strobe counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
ena  input  1  clock enable; low freezes all state, start/stop ignored
start  input  1  begin burst; accepted only in IDLE with ena=1
stop  input  1  abort burst; acted on in RUN with ena=1
period  input  PER_W  strobe spacing in cycles, latched at start; 0 treated as 1
count  input  NUM_W  strobes in burst, latched at start; 0 = continuous until stop
str  output  1  single-cycle strobe, registered
busy  output  1  burst in progress
done  output  1  single-cycle flag, coincident with final strobe of a finite burst

Behaviour:
- Reset (async, rst=1): state=IDLE, per_cnt=0, rem=0, per_q=0, inf_q=0, str=0, done=0. busy=0 follows from the reset state.
- FSM states: IDLE, RUN.
- str and done are cleared on every clock edge unless set by an event below.
  - Neither is ever high for more than one cycle per event.
  - Neither is ever set while ena=0.
- IDLE, on an edge with ena=1, start=1, stop=0:
  - per_q = max(period,1); inf_q = (count==0); rem = count.
  - Issue strobe: str=1, next cycle.
  - per_cnt = per_q-1.
  - If count==1: done=1 and state stays IDLE. Otherwise state=RUN and, when finite, rem=count-1.
  - Latency start->str is exactly 1 cycle.
- IDLE, start with stop=1 on the same edge: ignored; stop wins.
- RUN, edge with ena=1:
  - stop=1: state=IDLE, no strobe, no done. Stop takes precedence over a strobe due on the same edge.
  - Else if per_cnt==0: issue strobe, per_cnt=per_q-1.
    - If finite: rem decrements.
    - If the strobe is the last one (rem==1 before the decrement): done=1 on the same edge and state=IDLE.
  - Else: per_cnt decrements.
- Strobe spacing:
  - Consecutive str pulses are exactly per_q enabled cycles apart.
  - per_q=1 gives str high on every enabled cycle.
  - Cycles with ena=0 stretch the spacing one-for-one.
- start while in RUN is ignored. period/count changes during RUN have no effect until the next accepted start.
- busy = (state==RUN) | str. It is high from the first strobe through the final strobe, and low the cycle after it.
- Counters never wrap:
  - per_cnt is reloaded at 0.
  - rem is not decremented when inf_q=1.
  - PER_W-wide max period = 2^PER_W-1.
- Reset mid-burst: everything returns to reset values immediately, including a str already in flight.

Decomposition:
- Package strobe_pkg: state typedef (enum IDLE, RUN) and default width constants for PER_W/NUM_W, shared with pulse-stretcher instances and the bench.
- One natural sub-module: strobe_period_cnt.
  - Function: loadable down-counter with ena, producing a zero flag.
  - Used for per_cnt; rem may reuse it.
- FSM, latches and outputs stay in strobe_gen.

Test Plan:
- period=4, count=3, ena=1, start pulsed at cycle 0 -> str high at cycles 1, 5, 9 only; done high at cycle 9 only; busy high cycles 1-9, low from cycle 10.
- period=0, count=2, start at cycle 0 -> period treated as 1; str high cycles 1 and 2; done at cycle 2; count=1 gives single str at cycle 1 with done at cycle 1.
- period=3, count=0, start at cycle 0 -> str at 1, 4, 7, 10...; done never high; stop at cycle 8 -> no str at 10; busy low from cycle 9.
- period=4, count=2, start at 0, ena=0 for cycles 2-4 -> second str delayed from cycle 5 to cycle 8; no str or done during ena=0; start asserted during RUN is ignored.
- start and stop together in IDLE -> no str, busy stays 0; stop on the same edge a strobe is due (period=2, stop at cycle 2) -> no str at cycle 3.
- rst asserted mid-burst, asynchronously between edges -> str, done, busy drop to 0 immediately; after release, a new start behaves as a fresh burst.
